// File: rtl/us_timming_pkg.sv
// Shared types and widths for the us_timming transmit scheduler.
package us_timming_pkg;

    localparam int FLOW_W  = 128;
    localparam int GRANT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

endpackage

// File: rtl/us_timming_tx_scheduler_rr_pick.sv
// Combinational round-robin search: first eligible channel after ptr,
// wrapping around, with ptr itself checked last.
module rr_pick #(
    parameter int CH_NUM = 4,
    localparam int IW    = $clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0] elig,
    input  logic [IW-1:0]     ptr,
    output logic              hit,
    output logic [IW-1:0]     idx
);

    always_comb begin : search
        logic [IW:0] j;
        hit = 1'b0;
        idx = '0;
        j   = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            j = {1'b0, ptr} + (IW+1)'(i);
            if (j >= (IW+1)'(CH_NUM))
                j = j - (IW+1)'(CH_NUM);
            if (!hit && elig[j[IW-1:0]]) begin
                hit = 1'b1;
                idx = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/us_timming_tx_scheduler.sv
// Round-robin scheduler sharing one 128-bit transmit flow between
// CH_NUM request-driver channels, with timeout abort and inter-grant gap.
module us_timming_tx_scheduler
    import us_timming_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int CNT_W       = 12,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 4
) (
    input  logic                     sys_clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic [CNT_W-1:0]         thresh_i,
    input  logic [CH_NUM-1:0]        ch_empty_i,
    input  logic [CH_NUM*CNT_W-1:0]  ch_cache_count_i,
    output logic [CH_NUM-1:0]        ch_start_trigger_o,
    input  logic [CH_NUM-1:0]        ch_done_pulse_i,
    input  logic [CH_NUM-1:0]        ch_flow_vld_i,
    input  logic [CH_NUM*FLOW_W-1:0] ch_flow_i,
    output logic                     flow_vld_o,
    output logic [FLOW_W-1:0]        flow_o,
    output logic [GRANT_W-1:0]       grant_id_o,
    output logic                     busy_o,
    output logic                     timeout_err_o,
    output logic [GRANT_W-1:0]       timeout_ch_o
);

    localparam int IW = $clog2(CH_NUM);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gnt;
    logic [TW-1:0]     tmr;
    logic [GW-1:0]     gap_cnt;
    logic [CH_NUM-1:0] elig;
    logic              hit;
    logic [IW-1:0]     idx;
    logic              sel_vld;
    logic [FLOW_W-1:0] sel_flow;
    logic              fwd_en;

    always_comb begin
        elig = '0;
        for (int k = 0; k < CH_NUM; k++)
            elig[k] = !ch_empty_i[k] &&
                      (flush_i ||
                       ch_cache_count_i[k*CNT_W +: CNT_W] >= thresh_i);
    end

    rr_pick #(.CH_NUM(CH_NUM)) u_pick (
        .elig (elig),
        .ptr  (ptr),
        .hit  (hit),
        .idx  (idx)
    );

    assign grant_id_o = GRANT_W'(gnt);

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= ST_IDLE;
            ptr                <= IW'(CH_NUM - 1);
            gnt                <= '0;
            ch_start_trigger_o <= '0;
            busy_o             <= 1'b0;
            timeout_err_o      <= 1'b0;
            timeout_ch_o       <= '0;
            tmr                <= '0;
            gap_cnt            <= '0;
        end else begin
            timeout_err_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (enable_i && |elig)
                        state <= ST_ARB;
                end
                ST_ARB: begin
                    if (hit) begin
                        gnt                <= idx;
                        ptr                <= idx;
                        ch_start_trigger_o <= CH_NUM'(1) << idx;
                        busy_o             <= 1'b1;
                        state              <= ST_START;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    tmr   <= '0;
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // done is checked first so it wins over a same-cycle expiry
                    if (ch_done_pulse_i[gnt]) begin
                        ch_start_trigger_o <= '0;
                        busy_o             <= 1'b0;
                        gap_cnt            <= '0;
                        state              <= ST_GAP;
                    end else if (tmr == TMR_LAST) begin
                        ch_start_trigger_o <= '0;
                        busy_o             <= 1'b0;
                        timeout_err_o      <= 1'b1;
                        timeout_ch_o       <= GRANT_W'(gnt);
                        gap_cnt            <= '0;
                        state              <= ST_GAP;
                    end else if (tmr != '1) begin
                        tmr <= tmr + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sel_vld  = ch_flow_vld_i[gnt];
    assign sel_flow = ch_flow_i[int'(gnt)*FLOW_W +: FLOW_W];

    // the first GAP cycle is the one right after done; its flow still counts
    assign fwd_en = (state == ST_START) || (state == ST_WAIT_DONE) ||
                    ((state == ST_GAP) && (gap_cnt == '0));

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            flow_vld_o <= 1'b0;
            flow_o     <= '0;
        end else begin
            flow_vld_o <= fwd_en && sel_vld;
            if (sel_vld)
                flow_o <= sel_flow;
        end
    end

endmodule

// File: tb/tb_us_timming_tx_scheduler.sv
// Directed bench for us_timming_tx_scheduler: latency, gap, threshold,
// round robin, timeout, done/timeout coincidence, flow mux and reset.
module tb_us_timming_tx_scheduler;

    localparam int CH  = 4;
    localparam int CW  = 12;
    localparam int TO  = 64;
    localparam int GAP = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable;
    logic           flush;
    logic [CW-1:0]  thresh;
    logic [CH-1:0]  ch_empty;
    logic [CH*CW-1:0] cnt;
    logic [CH-1:0]  trig;
    logic [CH-1:0]  done;
    logic [CH-1:0]  fvld;
    logic [CH*128-1:0] flow;
    logic           flow_vld;
    logic [127:0]   flow_o;
    logic [2:0]     gid;
    logic           busy;
    logic           err;
    logic [2:0]     tch;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    us_timming_tx_scheduler #(
        .CH_NUM(CH), .CNT_W(CW), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
    ) dut (
        .sys_clk_i          (clk),
        .rst_i              (rst),
        .enable_i           (enable),
        .flush_i            (flush),
        .thresh_i           (thresh),
        .ch_empty_i         (ch_empty),
        .ch_cache_count_i   (cnt),
        .ch_start_trigger_o (trig),
        .ch_done_pulse_i    (done),
        .ch_flow_vld_i      (fvld),
        .ch_flow_i          (flow),
        .flow_vld_o         (flow_vld),
        .flow_o             (flow_o),
        .grant_id_o         (gid),
        .busy_o             (busy),
        .timeout_err_o      (err),
        .timeout_ch_o       (tch)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(output int n);
        n = 0;
        while (trig == '0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        flush  = 1'b0;
        done   = '0;
        fvld   = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_cnt(input int k, input logic [CW-1:0] v);
        cnt[k*CW +: CW] = v;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        int err_at, drop_at, errs;
        logic [3:0] m;
        int order [11];
        logic [127:0] pat_a5, pat_5a, pat_3c;

        order  = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3};
        pat_a5 = {16{8'hA5}};
        pat_5a = {16{8'h5A}};
        pat_3c = {16{8'h3C}};
        enable = 0; flush = 0; thresh = 12; ch_empty = 4'hF;
        cnt = '0; done = '0; fvld = '0; flow = '0;

        // reset values
        tick(); tick();
        chk("rst trig", trig, 0);
        chk("rst fvld", flow_vld, 0);
        chk("rst flow", flow_o, 0);
        chk("rst gid", gid, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        chk("rst tch", tch, 0);
        rst = 0;
        tick();

        // single channel: IDLE -> ARB -> START
        set_cnt(0, 12);
        ch_empty[0] = 1'b0;
        enable = 1;
        tick();
        chk("lat1 trig", trig, 0);
        tick();
        chk("lat2 trig", trig, 4'b0001);
        chk("lat2 busy", busy, 1);
        chk("lat2 gid", gid, 0);
        repeat (20) tick();
        chk("hold trig", trig, 4'b0001);
        done[0] = 1; tick(); done = 0;
        chk("done trig", trig, 0);
        chk("done busy", busy, 0);
        // 4 GAP cycles remain, then IDLE, ARB, START
        n = 0;
        while (trig == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("gap regrant", n, 6);

        // threshold gate, then flush
        set_cnt(0, 11);
        repeat (3) tick();
        done[0] = 1; tick(); done = 0;
        repeat (20) tick();
        chk("thresh trig", trig, 0);
        chk("thresh busy", busy, 0);
        flush = 1;
        wait_trig(n);
        chk("flush trig", trig, 4'b0001);
        done[0] = 1; tick(); done = 0;
        flush = 0;
        enable = 0;
        repeat (8) tick();

        // round robin
        do_reset();
        for (int k = 0; k < CH; k++) set_cnt(k, 12);
        ch_empty = 4'h0;
        enable = 1;
        for (int i = 0; i < 11; i++) begin
            wait_trig(n);
            m = 4'b0001 << order[i];
            chk($sformatf("rr%0d trig", i), trig, m);
            chk($sformatf("rr%0d gid", i), gid, order[i]);
            if (i == 6) ch_empty[2] = 1'b1;
            repeat (10) tick();
            done = m; tick(); done = 0;
        end
        enable = 0;
        repeat (8) tick();

        // timeout on channel 1: 1 START + 64 WAIT_DONE cycles
        do_reset();
        ch_empty = 4'b1001;
        enable = 1;
        wait_trig(n);
        chk("to trig", trig, 4'b0010);
        err_at = 0; drop_at = 0; errs = 0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (err) begin
                errs++;
                if (err_at == 0) err_at = i;
            end
            if (trig == '0 && drop_at == 0) drop_at = i;
        end
        chk("to err_at", err_at, 65);
        chk("to errs", errs, 1);
        chk("to drop_at", drop_at, 65);
        chk("to tch", tch, 1);
        wait_trig(n);
        chk("to next", trig, 4'b0100);
        done[2] = 1; tick(); done = 0;
        enable = 0;
        repeat (8) tick();

        // spurious done, then done coinciding with expiry
        do_reset();
        ch_empty = 4'b1101;
        enable = 1;
        wait_trig(n);
        repeat (4) tick();
        done[3] = 1; tick(); done = 0;
        chk("spur trig", trig, 4'b0010);
        repeat (59) tick();
        chk("coin pre", trig, 4'b0010);
        done[1] = 1; tick(); done = 0;
        chk("coin err", err, 0);
        chk("coin trig", trig, 0);
        chk("coin tch", tch, 0);
        tick();
        chk("coin err2", err, 0);
        enable = 0;
        repeat (8) tick();

        // flow mux on channel 2
        do_reset();
        ch_empty = 4'b1011;
        enable = 1;
        wait_trig(n);
        tick();
        flow[2*128 +: 128] = pat_a5;
        flow[0 +: 128]     = pat_3c;
        fvld = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl%0d vld", i), flow_vld, 1);
            chk($sformatf("fl%0d data", i), flow_o, pat_a5);
        end
        fvld = 4'b0001;
        tick();
        chk("fl ch0 vld", flow_vld, 0);
        chk("fl ch0 data", flow_o, pat_a5);
        fvld = 0;
        done[2] = 1; tick(); done = 0;
        flow[2*128 +: 128] = pat_5a;
        fvld[2] = 1;
        tick();
        chk("postdone vld", flow_vld, 1);
        chk("postdone data", flow_o, pat_5a);
        tick();
        chk("gap vld", flow_vld, 0);
        fvld = 0;

        // reset in the middle of WAIT_DONE
        wait_trig(n);
        tick();
        fvld[2] = 1;
        tick();
        chk("prerst vld", flow_vld, 1);
        rst = 1;
        #1;
        chk("mrst trig", trig, 0);
        chk("mrst vld", flow_vld, 0);
        chk("mrst busy", busy, 0);
        chk("mrst err", err, 0);
        tick();
        chk("mrst err2", err, 0);
        rst = 0;
        fvld = 0;
        enable = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/us_timming_tx_scheduler.md
Name: us_timming_tx_scheduler

Overview:
- Shares one downstream 128-bit transmit flow between CH_NUM us_timming request-driver channels.
- Each channel has its own cache FIFO and its own request driver. The scheduler selects one eligible channel round-robin and holds that channel's start trigger until the channel reports done or times out.
- The granted channel's flow is forwarded through one register stage to the framing/transmit logic.

Parameters:
- CH_NUM, 4, number of request-driver channels (2..8).
- CNT_W, 12, width of each channel cache count.
- TIMEOUT_CYC, 4096, maximum cycles in WAIT_DONE before abort.
- GAP_CYC, 4, idle cycles enforced between consecutive grants (must be >=1).

Ports:
- sys_clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- enable_i  in  1  scheduling enable; sampled only in IDLE.
- flush_i  in  1  treat any non-empty channel as eligible, ignoring the threshold.
- thresh_i  in  CNT_W  minimum cache count for eligibility.
- ch_empty_i  in  CH_NUM  per-channel FIFO empty.
- ch_cache_count_i  in  CH_NUM*CNT_W  per-channel cache count; channel k occupies bits [k*CNT_W +: CNT_W].
- ch_start_trigger_o  out  CH_NUM  per-channel transmit start trigger, level.
- ch_done_pulse_i  in  CH_NUM  per-channel transmit done pulse, 1 cycle.
- ch_flow_vld_i  in  CH_NUM  per-channel flow valid.
- ch_flow_i  in  CH_NUM*128  per-channel flow data; channel k occupies bits [k*128 +: 128].
- flow_vld_o  out  1  muxed flow valid, registered.
- flow_o  out  128  muxed flow data, registered.
- grant_id_o  out  3  currently or last granted channel.
- busy_o  out  1  high in START and WAIT_DONE.
- timeout_err_o  out  1  1-cycle pulse on abort.
- timeout_ch_o  out  3  channel of the last timeout.

Behaviour:
- Reset values:
  - all outputs 0.
  - FSM state IDLE.
  - round-robin pointer = CH_NUM-1, so channel 0 has first priority.
  - timers cleared.
- Reset mid-operation clears everything immediately. No done or timeout pulse is generated for the aborted grant.
- Eligibility of channel k: elig[k] = !ch_empty_i[k] && (flush_i || count_k >= thresh_i). The comparison is unsigned. thresh_i = 0 means "any non-empty".
- FSM states and transitions:
  - IDLE: if enable_i && |elig, go to ARB. Otherwise stay.
  - ARB (1 cycle):
    - Search from pointer+1 upward with wrap-around, using elig recomputed this cycle.
    - First hit becomes grant_id_o and pointer := grant. Go to START.
    - If no hit (eligibility vanished), return to IDLE.
  - START (1 cycle):
    - Assert ch_start_trigger_o[grant] and raise busy_o.
    - Clear the timeout counter. Go to WAIT_DONE.
  - WAIT_DONE:
    - ch_start_trigger_o[grant] stays high.
    - On ch_done_pulse_i[grant]: drop the trigger next cycle and go to GAP.
    - Else, if the timer reaches TIMEOUT_CYC-1: drop the trigger, pulse timeout_err_o, latch timeout_ch_o = grant, go to GAP.
    - If done and timeout coincide in the same cycle, done wins and no error is raised.
  - GAP: count GAP_CYC cycles with all triggers low, then go to IDLE.
- Only one bit of ch_start_trigger_o is ever high. Trigger latency is 2 cycles from IDLE seeing an eligible channel to the trigger rising.
- ch_done_pulse_i from non-granted channels is ignored in every state.
- enable_i deasserted during START, WAIT_DONE or GAP does not abort: the current transfer completes, then the FSM stays in IDLE.
- Datapath:
  - flow_vld_o <= busy_state && ch_flow_vld_i[grant].
  - flow_o <= ch_flow_i[grant] when that channel is valid; otherwise flow_o holds its value.
  - Latency is 1 cycle.
  - Flow valid seen in the cycle the trigger drops (the cycle after done) is still forwarded. Flow valid in GAP and IDLE is dropped.
- The timer is log2(TIMEOUT_CYC)+1 bits wide and saturates. The gap counter is sized for GAP_CYC.

Decomposition:
- Package us_timming_pkg holds:
  - state encoding constants (IDLE, ARB, START, WAIT_DONE, GAP);
  - FLOW_W = 128;
  - GRANT_W = 3.
- One sub-module, rr_pick: combinational round-robin search with inputs elig[CH_NUM] and ptr, and outputs hit and idx. It is reused by other arbiters in the design.
- FSM, timers and flow register stay in the top module.

Test Plan:
- Single channel: reset, then CH_NUM=4, thresh_i=12, channel 0 empty=0 with count=12, enable_i=1.
  - Required: ch_start_trigger_o=4'b0001 rises 2 cycles after enable.
  - Drive done 20 cycles later. Required: trigger falls next cycle, then GAP_CYC=4 idle cycles, then IDLE.
- Threshold gate: channel 0 count=11, thresh_i=12.
  - Required: no grant.
  - Then assert flush_i=1. Required: grant to channel 0.
- Round robin: all 4 channels eligible, each done after 10 cycles.
  - Required grant order: 0, 1, 2, 3, 0.
  - Then with channel 2 made empty: order 3, 0, 1, 3.
- Timeout: TIMEOUT_CYC=64, channel 1 granted, no done.
  - Required: trigger drops, timeout_err_o pulses exactly once 64 cycles after START, timeout_ch_o=1, next grant is channel 2.
- Coincidence and spurious done:
  - Done on channel 3 while channel 1 is granted is ignored.
  - Done asserted on the same cycle as timeout expiry: required no timeout_err_o.
- Flow mux and reset:
  - Channel 2 granted, ch_flow_i[2]=128'hA5..A5 valid for 3 cycles. Required: flow_o matches 1 cycle later, with flow_vld_o high for 3 cycles; valid from channel 0 during this time is dropped.
  - Assert rst_i mid-WAIT_DONE. Required: trigger, flow_vld_o and busy_o go to 0 immediately, with no error pulse.
